// File: rtl/ether_tx.sv
// RMII transmit framer: preamble, SFD, payload, optional zero-pad, FCS and
// inter-packet gap, driven from a dibit valid/ready/last stream.
module ether_tx #(
    parameter int PAD_EN     = 1,
    parameter int MIN_DIBITS = 240,
    parameter int IPG_DIBITS = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    input  logic       axiil,
    output logic       axiir,
    output logic       txen,
    output logic [1:0] txd,
    output logic       underrun
);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IPG} state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [12:0] CNT_MAX  = 13'h1FFF;
    localparam logic [12:0] MIN_CNT  = 13'(MIN_DIBITS);
    localparam logic [7:0]  PRE_LAST = 8'd31;
    localparam logic [7:0]  IPG_LAST = 8'(IPG_DIBITS - 1);

    state_t      state;
    logic [31:0] crc;
    logic [31:0] crc_inv;
    logic [12:0] cnt;
    logic [12:0] cnt_nxt;
    logic [7:0]  tmr;

    // Reflected CRC-32, two bits per call, d[0] shifted in first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [12:0] sat_inc(input logic [12:0] v);
        return (v == CNT_MAX) ? v : v + 13'd1;
    endfunction

    assign cnt_nxt = sat_inc(cnt);
    assign crc_inv = ~crc;
    assign axiir   = (state == SFD) || (state == DATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            txen     <= 1'b0;
            txd      <= 2'b00;
            underrun <= 1'b0;
            crc      <= CRC_INIT;
            cnt      <= '0;
            tmr      <= '0;
        end else begin
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    txen <= 1'b0;
                    txd  <= 2'b00;
                    if (axiiv) begin
                        state <= PRE;
                        txen  <= 1'b1;
                        txd   <= 2'b01;
                        tmr   <= 8'd1;
                    end
                end
                PRE: begin
                    if (tmr == PRE_LAST) begin
                        state <= SFD;
                        txd   <= 2'b11;
                        tmr   <= '0;
                    end else begin
                        txd <= 2'b01;
                        tmr <= tmr + 8'd1;
                    end
                end
                SFD, DATA: begin
                    if (axiiv) begin
                        txd <= axiid;
                        crc <= crc_dibit(crc, axiid);
                        cnt <= cnt_nxt;
                        if (axiil) begin
                            tmr <= '0;
                            if (PAD_EN != 0 && cnt_nxt < MIN_CNT) begin
                                state <= PAD;
                            end else begin
                                state <= FCS;
                            end
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        // Source starved us mid-frame: abort without FCS.
                        state    <= IPG;
                        txen     <= 1'b0;
                        txd      <= 2'b00;
                        underrun <= 1'b1;
                        crc      <= CRC_INIT;
                        cnt      <= '0;
                        tmr      <= '0;
                    end
                end
                PAD: begin
                    txd <= 2'b00;
                    crc <= crc_dibit(crc, 2'b00);
                    cnt <= cnt_nxt;
                    if (cnt_nxt >= MIN_CNT) begin
                        state <= FCS;
                        tmr   <= '0;
                    end
                end
                FCS: begin
                    txd <= crc_inv[{tmr[3:0], 1'b0} +: 2];
                    if (tmr[3:0] == 4'd15) begin
                        state <= IPG;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                IPG: begin
                    txen <= 1'b0;
                    txd  <= 2'b00;
                    crc  <= CRC_INIT;
                    cnt  <= '0;
                    if (tmr == IPG_LAST) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ether_tx.sv
// Scoreboard bench for ether_tx: one padding and one non-padding instance
// share the input stream; monitors pop expected dibits whenever txen is high.
module tb_ether_tx;

    localparam int MIN_DIBITS = 240;
    localparam int IPG_DIBITS = 48;

    logic       clk;
    logic       rst;
    logic       axiiv;
    logic [1:0] axiid;
    logic       axiil;
    logic       axiir_np, txen_np, underrun_np;
    logic [1:0] txd_np;
    logic       axiir_p, txen_p, underrun_p;
    logic [1:0] txd_p;

    int checks   = 0;
    int failures = 0;

    logic [1:0] pl [0:511];
    logic [1:0] exp_np[$];
    logic [1:0] exp_p[$];

    int hi_np = 0, lo_np = 0, last_hi_np = 0, last_gap_np = 0, urun_np = 0;
    int hi_p  = 0, lo_p  = 0, last_hi_p  = 0, last_gap_p  = 0, urun_p  = 0;

    ether_tx #(.PAD_EN(0), .MIN_DIBITS(MIN_DIBITS), .IPG_DIBITS(IPG_DIBITS)) dut_np (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiil(axiil),
        .axiir(axiir_np), .txen(txen_np), .txd(txd_np), .underrun(underrun_np)
    );

    ether_tx #(.PAD_EN(1), .MIN_DIBITS(MIN_DIBITS), .IPG_DIBITS(IPG_DIBITS)) dut_p (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid), .axiil(axiil),
        .axiir(axiir_p), .txen(txen_p), .txd(txd_p), .underrun(underrun_p)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [31:0] model_crc(input int start, input int n, input int plen);
        logic [31:0] c;
        logic [1:0]  d;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < plen; i++) begin
            d = (i < n) ? pl[start + i] : 2'b00;
            for (int b = 0; b < 2; b++) begin
                if (c[0] ^ d[b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else             c = c >> 1;
            end
        end
        return c;
    endfunction

    // sent >= 0 means the frame is aborted after that many dibits.
    task automatic push_frame(input int start, input int n, input int sent, input bit hand);
        logic [31:0] fcs_np, fcs_p;
        int plen;
        for (int i = 0; i < 31; i++) begin
            exp_np.push_back(2'b01);
            exp_p.push_back(2'b01);
        end
        exp_np.push_back(2'b11);
        exp_p.push_back(2'b11);
        if (sent >= 0) begin
            for (int i = 0; i < sent; i++) begin
                exp_np.push_back(pl[start + i]);
                exp_p.push_back(pl[start + i]);
            end
            return;
        end
        for (int i = 0; i < n; i++) begin
            exp_np.push_back(pl[start + i]);
            exp_p.push_back(pl[start + i]);
        end
        plen = (n < MIN_DIBITS) ? MIN_DIBITS : n;
        for (int i = n; i < plen; i++) exp_p.push_back(2'b00);
        fcs_np = hand ? 32'hCBF4_3926 : ~model_crc(start, n, n);
        fcs_p  = ~model_crc(start, n, plen);
        for (int i = 0; i < 16; i++) begin
            exp_np.push_back(fcs_np[2*i +: 2]);
            exp_p.push_back(fcs_p[2*i +: 2]);
        end
    endtask

    // Called at a negedge; returns at the negedge after the last transfer.
    task automatic drive_frame(input int start, input int n, input int drop_at);
        int idx;
        int guard;
        bit pend;
        idx   = 0;
        guard = 0;
        axiiv = 1'b1;
        axiid = pl[start];
        axiil = (n == 1);
        pend  = axiir_np;
        while (idx < n) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check("drive_timeout", 32'(idx), 32'(n));
                break;
            end
            if (pend) idx++;
            if (idx >= n) break;
            if (idx == drop_at && axiir_np) begin
                axiiv = 1'b0;
                @(posedge clk);
                #1;
                check("urun_txen_np", 32'(txen_np), 0);
                check("urun_txen_p", 32'(txen_p), 0);
                check("urun_pulse_np", 32'(underrun_np), 1);
                check("urun_pulse_p", 32'(underrun_p), 1);
                return;
            end
            axiid = pl[start + idx];
            axiil = (idx == n - 1);
            pend  = axiir_np;
        end
    endtask

    task automatic check_preamble();
        int bad;
        bad = 0;
        @(posedge clk);
        #1;
        check("pre_txen_k1", 32'(txen_np), 1);
        check("pre_txd_k1", 32'(txd_np), 32'd1);
        check("pre_rdy_k1", 32'(axiir_np), 0);
        repeat (30) begin
            @(posedge clk);
            #1;
            if (axiir_np || axiir_p) bad++;
        end
        check("pre_rdy_low", 32'(bad), 0);
        @(posedge clk);
        #1;
        check("sfd_txd", 32'(txd_np), 32'd3);
        check("sfd_rdy", 32'(axiir_np), 1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((exp_np.size() != 0 || exp_p.size() != 0 || txen_np || txen_p) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) check("idle_timeout", 32'(txen_np | txen_p), 0);
        repeat (IPG_DIBITS + 4) @(negedge clk);
    endtask

    initial begin : mon_np
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst && txen_np) begin
                if (exp_np.size() == 0) check("np_txen_extra", 32'(txen_np), 0);
                else begin
                    e = exp_np.pop_front();
                    check("np_txd", 32'(txd_np), 32'(e));
                end
            end
            if (underrun_np) urun_np++;
            if (txen_np) begin
                if (lo_np > 0) last_gap_np = lo_np;
                lo_np = 0;
                hi_np++;
            end else begin
                if (hi_np > 0) last_hi_np = hi_np;
                hi_np = 0;
                lo_np++;
            end
        end
    end

    initial begin : mon_p
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (rst && txen_p) begin
                if (exp_p.size() == 0) check("p_txen_extra", 32'(txen_p), 0);
                else begin
                    e = exp_p.pop_front();
                    check("p_txd", 32'(txd_p), 32'(e));
                end
            end
            if (underrun_p) urun_p++;
            if (txen_p) begin
                if (lo_p > 0) last_gap_p = lo_p;
                lo_p = 0;
                hi_p++;
            end else begin
                if (hi_p > 0) last_hi_p = hi_p;
                hi_p = 0;
                lo_p++;
            end
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] by;
        int u0_np, u0_p;
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        axiil = 1'b0;
        #1;
        check("rst_txen_np", 32'(txen_np), 0);
        check("rst_txd_np", 32'(txd_np), 0);
        check("rst_rdy_np", 32'(axiir_np), 0);
        check("rst_urun_np", 32'(underrun_np), 0);
        check("rst_txen_p", 32'(txen_p), 0);
        check("rst_rdy_p", 32'(axiir_p), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_txen", 32'(txen_np), 0);

        // "123456789", byte LSB dibit first.
        for (int i = 0; i < 9; i++) begin
            by = 8'h31 + 8'(i);
            for (int j = 0; j < 4; j++) pl[4*i + j] = by[2*j +: 2];
        end
        push_frame(0, 36, -1, 1'b1);
        fork
            drive_frame(0, 36, -1);
            check_preamble();
        join
        check("last_rdy_np", 32'(axiir_np), 0);
        check("last_rdy_p", 32'(axiir_p), 0);
        axiiv = 1'b0;
        wait_idle();
        check("crc_frame_hi_np", 32'(last_hi_np), 32'd84);
        check("crc_frame_hi_p", 32'(last_hi_p), 32'd288);

        // Short payload padded to the minimum length.
        pl[0] = 2'b11; pl[1] = 2'b01; pl[2] = 2'b10; pl[3] = 2'b00;
        push_frame(0, 4, -1, 1'b0);
        drive_frame(0, 4, -1);
        axiiv = 1'b0;
        wait_idle();
        check("pad_hi_p", 32'(last_hi_p), 32'd288);
        check("pad_hi_np", 32'(last_hi_np), 32'd52);

        // Underrun mid-DATA followed by an immediate recovery frame.
        for (int i = 0; i < 28; i++) pl[i] = 2'((i * 3 + 1) % 4);
        u0_np = urun_np;
        u0_p  = urun_p;
        push_frame(0, 20, 10, 1'b0);
        push_frame(20, 8, -1, 1'b0);
        drive_frame(0, 20, 10);
        @(negedge clk);
        drive_frame(20, 8, -1);
        axiiv = 1'b0;
        wait_idle();
        check("urun_count_np", 32'(urun_np - u0_np), 1);
        check("urun_count_p", 32'(urun_p - u0_p), 1);
        check("urun_gap_np", 32'(last_gap_np >= IPG_DIBITS), 1);
        check("urun_gap_p", 32'(last_gap_p >= IPG_DIBITS), 1);

        // Back-to-back frames.
        for (int i = 0; i < 490; i++) pl[i] = 2'((i * 5 + i / 7) % 4);
        push_frame(0, 240, -1, 1'b0);
        push_frame(240, 250, -1, 1'b0);
        drive_frame(0, 240, -1);
        drive_frame(240, 250, -1);
        axiiv = 1'b0;
        wait_idle();
        check("b2b_gap_np", 32'(last_gap_np), 32'd48);
        check("b2b_gap_p", 32'(last_gap_p), 32'd48);

        // Asynchronous reset in the middle of FCS.
        for (int i = 0; i < 240; i++) pl[i] = 2'((i * 7 + 2) % 4);
        push_frame(0, 240, -1, 1'b0);
        drive_frame(0, 240, -1);
        axiiv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        check("arst_txen_np", 32'(txen_np), 0);
        check("arst_txd_np", 32'(txd_np), 0);
        check("arst_rdy_np", 32'(axiir_np), 0);
        check("arst_txen_p", 32'(txen_p), 0);
        check("arst_txd_p", 32'(txd_p), 0);
        check("arst_rdy_p", 32'(axiir_p), 0);
        exp_np.delete();
        exp_p.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_txen", 32'(txen_np), 0);
        check("post_rst_rdy", 32'(axiir_np), 0);
        for (int i = 0; i < 8; i++) pl[i] = 2'((i + 3) % 4);
        push_frame(0, 8, -1, 1'b0);
        drive_frame(0, 8, -1);
        axiiv = 1'b0;
        wait_idle();

        check("exp_np_drained", 32'(exp_np.size()), 0);
        check("exp_p_drained", 32'(exp_p.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ether_tx.md
Name: ether_tx

Overview:
RMII transmit framer. It is the transmit-side counterpart of the ether receiver.
- Accepts a frame payload as a dibit stream with a valid/ready/last handshake.
- Drives txen/txd at 50 MHz RMII rate: 31 preamble dibits, SFD, payload, optional zero-pad to minimum frame length, 32-bit FCS, then the inter-packet gap.
- Sits between the packet-assembly logic and the PHY TX pins.

Parameters:
PAD_EN, 1, 1 = zero-pad payload to MIN_DIBITS before FCS; 0 = no padding
MIN_DIBITS, 240, minimum payload length in dibits before FCS (60 bytes)
IPG_DIBITS, 48, inter-packet gap length in cycles with txen low (96 bit times)

Ports:
clk  input  1  50 MHz RMII reference clock
rst  input  1  asynchronous, active-low reset
axiiv  input  1  input dibit valid
axiid  input  2  input dibit, wire order (byte LSB dibit first, bit0 in axiid[0])
axiil  input  1  marks last dibit of frame; qualified by axiiv
axiir  output  1  ready; a transfer occurs on cycles with axiiv && axiir
txen  output  1  RMII TX_EN
txd  output  2  RMII TXD
underrun  output  1  one-cycle pulse when a frame is aborted for missing data

Behaviour:
- Reset (rst low, asynchronous): state IDLE; txen=0, txd=00, axiir=0, underrun=0; CRC register = 0xFFFFFFFF; all counters = 0.
- Registered outputs:
  - txen, txd and underrun are registered.
  - axiir is decoded from the state register only.
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IPG.
- IDLE:
  - txen=0, txd=00, axiir=0.
  - axiiv sampled high at edge k moves the state to PRE. The data is not consumed.
  - txd=01, txen=1 from the cycle after edge k.
- PRE: 31 cycles of txd=01, then SFD.
- SFD:
  - 1 cycle of txd=11.
  - axiir=1 in this cycle. A transfer here appears on txd in the next cycle (first data dibit).
  - No transfer in the SFD cycle means an underrun.
- DATA:
  - axiir=1. Each transfer puts axiid on txd next cycle, updates the CRC and increments the dibit counter.
  - The counter is 13 bits and saturates.
  - axiiv low while axiir=1 (SFD or DATA) is an underrun:
    - txen=0 and txd=00 next cycle.
    - underrun pulses for 1 cycle.
    - CRC and counter reset; go to IPG.
- Transfer with axiil=1:
  - If PAD_EN=1 and the count after this dibit is < MIN_DIBITS, go to PAD.
  - Otherwise go to FCS.
  - axiir drops the cycle after the last transfer.
- PAD:
  - txd=00 and txen=1 per cycle, CRC-updated and counted, until the count reaches MIN_DIBITS; then FCS.
  - A last dibit exactly at MIN_DIBITS skips PAD.
- CRC:
  - IEEE 802.3 reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - 2 bits per cycle, axiid[0] processed first.
- FCS:
  - 16 cycles transmitting ~crc, bits [1:0] first, then [3:2], and so on up to [31:30].
  - CRC is frozen during FCS.
  - Then IPG.
- IPG:
  - IPG_DIBITS cycles with txen=0, txd=00, axiir=0.
  - Counter and CRC are reinitialised, then IDLE.
  - axiiv held high throughout starts the next preamble the cycle after IDLE is entered.
- axiil is ignored unless transferred. axiid and axiil are don't-care when axiiv=0.
- Reset mid-frame: txen drops asynchronously and no FCS is sent.

Test Plan:
- Frame "123456789":
  - Stimulus: 36 dibits (0x31 sent as 01,00,11,00 …), axiil on dibit 36, PAD_EN=0, axiiv held.
  - Required: 31×01 then 11; payload echoed one cycle after each transfer; FCS bytes 0x26,0x39,0xF4,0xCB, with 0x26 sent as 10,01,10,00; then 48 cycles txen=0.
- Preamble timing:
  - Stimulus: axiiv rises at edge k.
  - Required: txen=1 at k+1; SFD (11) at k+32; axiir high only from k+32; no dibit consumed before k+32.
- Padding:
  - Stimulus: PAD_EN=1, a 4-dibit payload.
  - Required: 236 txd=00 dibits follow the payload, then 16 FCS dibits equal to the CRC of the 240-dibit payload; txen stays high for 32+240+16=288 cycles.
- Underrun:
  - Stimulus: drop axiiv mid-DATA for one cycle.
  - Required: txen=0 next cycle; one underrun pulse; no FCS; 48 IPG cycles; the next frame starts cleanly with preamble.
- Back-to-back:
  - Stimulus: second frame presented immediately after axiil.
  - Required: exactly 48 txen-low cycles between the frames; the second FCS is correct, proving CRC reinit.
- Async reset:
  - Stimulus: assert rst low during FCS.
  - Required: txen=0, txd=00, axiir=0 immediately without a clock edge; after release, IDLE.
